// File: rtl/conv_kernel_scheduler.sv
// Shares one convolution engine across a bank of stored kernels and tags each result with its kernel index.
// Build option: define CONV_SCHED_MASK_EN to add a per-window kernel enable mask (kernel_mask_i).
module conv_kernel_scheduler #(
  parameter int  EXP_WIDTH     = 5,
  parameter int  FRAC_WIDTH    = 10,
  parameter int  WINDOW_WIDTH  = 5,
  parameter int  WINDOW_HEIGHT = 5,
  parameter int  NUM_KERNELS   = 2,
  parameter int  TAG_DEPTH     = 32,
  localparam int FP_WIDTH      = 1 + EXP_WIDTH + FRAC_WIDTH,
  localparam int KIDX_W        = (NUM_KERNELS > 1) ? $clog2(NUM_KERNELS) : 1
) (
  input  logic                                                       clk_i,
  input  logic                                                       rst_i,
  input  logic                                                       cfg_we_i,
  input  logic [KIDX_W-1:0]                                          cfg_kidx_i,
  input  logic [7:0]                                                 cfg_row_i,
  input  logic [7:0]                                                 cfg_col_i,
  input  logic [FP_WIDTH-1:0]                                        cfg_data_i,
  output logic                                                       cfg_err_o,
  input  logic [WINDOW_HEIGHT-1:0][WINDOW_WIDTH-1:0][FP_WIDTH-1:0]   window_i,
  input  logic [15:0]                                                col_i,
  input  logic [15:0]                                                row_i,
  input  logic                                                       valid_i,
`ifdef CONV_SCHED_MASK_EN
  input  logic [NUM_KERNELS-1:0]                                     kernel_mask_i,
`endif
  output logic                                                       ready_o,
  output logic [WINDOW_HEIGHT-1:0][WINDOW_WIDTH-1:0][FP_WIDTH-1:0]   eng_window_o,
  output logic [WINDOW_HEIGHT-1:0][WINDOW_WIDTH-1:0][FP_WIDTH-1:0]   eng_kernel_o,
  output logic [15:0]                                                eng_col_o,
  output logic [15:0]                                                eng_row_o,
  output logic                                                       eng_valid_o,
  input  logic [FP_WIDTH-1:0]                                        eng_data_i,
  input  logic [15:0]                                                eng_col_i,
  input  logic [15:0]                                                eng_row_i,
  input  logic                                                       eng_valid_i,
  output logic [FP_WIDTH-1:0]                                        data_o,
  output logic [KIDX_W-1:0]                                          kidx_o,
  output logic [15:0]                                                col_o,
  output logic [15:0]                                                row_o,
  output logic                                                       valid_o,
  output logic                                                       busy_o,
  output logic                                                       tag_err_o
);

  localparam int PTR_W = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
  localparam int CNT_W = $clog2(TAG_DEPTH + 1);

  typedef logic [WINDOW_HEIGHT-1:0][WINDOW_WIDTH-1:0][FP_WIDTH-1:0] win_t;
  typedef enum logic [0:0] {IDLE = 1'b0, ISSUE = 1'b1} state_t;

  // True when some enabled kernel has index >= start.
  function automatic logic any_from(input logic [NUM_KERNELS-1:0] mask, input int start);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < NUM_KERNELS; i++) begin
      if ((i >= start) && mask[i]) hit = 1'b1;
    end
    return hit;
  endfunction

  // Lowest enabled kernel index >= start (0 when none).
  function automatic logic [KIDX_W-1:0] idx_from(input logic [NUM_KERNELS-1:0] mask, input int start);
    logic [KIDX_W-1:0] idx;
    idx = '0;
    for (int i = NUM_KERNELS - 1; i >= 0; i--) begin
      if ((i >= start) && mask[i]) idx = KIDX_W'(i);
    end
    return idx;
  endfunction

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(TAG_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  state_t                 state_r, state_next_s;
  logic [KIDX_W-1:0]      k_r, k_next_s;
  logic [NUM_KERNELS-1:0] mask_in_s, mask_cur_s, mask_next_s;
  logic                   accept_s, issue_next_s, ready_next_s, busy_next_s;
  logic                   first_found_s, more_found_s;
  logic [KIDX_W-1:0]      first_idx_s, more_idx_s;
  logic                   cfg_ok_s;

  win_t                   bank_r [NUM_KERNELS];
  win_t                   win_r, kernel_r;
  logic [15:0]            col_lat_r, row_lat_r;
  logic                   eng_valid_r, ready_r, busy_r, cfg_err_r, tag_err_r;
  logic [FP_WIDTH-1:0]    data_r;
  logic [KIDX_W-1:0]      kidx_r;
  logic [15:0]            res_col_r, res_row_r;
  logic                   valid_r;

  logic [KIDX_W-1:0]      tag_mem_r [TAG_DEPTH];
  logic [PTR_W-1:0]       wr_ptr_r, rd_ptr_r;
  logic [CNT_W-1:0]       tag_cnt_r, tag_cnt_next_s;
  logic                   push_s, pop_s, empty_s, full_s, bypass_s, push_wr_s, pop_rd_s, tag_err_set_s;
  logic [KIDX_W-1:0]      pop_tag_s;

`ifdef CONV_SCHED_MASK_EN
  logic [NUM_KERNELS-1:0] mask_r;
  assign mask_in_s  = kernel_mask_i;
  assign mask_cur_s = mask_r;

  // Kernel mask captured with each accepted window.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      mask_r <= {NUM_KERNELS{1'b0}};
    end else if (accept_s) begin
      mask_r <= kernel_mask_i;
    end
  end
`else
  assign mask_in_s  = {NUM_KERNELS{1'b1}};
  assign mask_cur_s = {NUM_KERNELS{1'b1}};
`endif

  assign accept_s      = valid_i && ready_r;
  assign first_found_s = any_from(mask_in_s, 0);
  assign first_idx_s   = idx_from(mask_in_s, 0);
  assign more_found_s  = any_from(mask_cur_s, int'(k_r) + 1);
  assign more_idx_s    = idx_from(mask_cur_s, int'(k_r) + 1);

  // Next-state decode: walk the enabled kernels, chaining straight into the next window.
  always_comb begin
    state_next_s = state_r;
    k_next_s     = k_r;
    issue_next_s = 1'b0;
    mask_next_s  = accept_s ? mask_in_s : mask_cur_s;
    case (state_r)
      IDLE: begin
        if (accept_s && first_found_s) begin
          state_next_s = ISSUE;
          k_next_s     = first_idx_s;
          issue_next_s = 1'b1;
        end else begin
          state_next_s = IDLE;
        end
      end
      ISSUE: begin
        if (more_found_s) begin
          k_next_s     = more_idx_s;
          issue_next_s = 1'b1;
        end else if (accept_s && first_found_s) begin
          k_next_s     = first_idx_s;
          issue_next_s = 1'b1;
        end else begin
          state_next_s = IDLE;
          k_next_s     = '0;
        end
      end
      default: begin
        state_next_s = IDLE;
        k_next_s     = '0;
      end
    endcase
    ready_next_s = (state_next_s == IDLE) || !any_from(mask_next_s, int'(k_next_s) + 1);
  end

  // Tag FIFO control; an empty FIFO popped while pushing forwards the tag straight through.
  always_comb begin
    push_s         = eng_valid_r;
    pop_s          = eng_valid_i;
    empty_s        = (tag_cnt_r == '0);
    full_s         = (tag_cnt_r == CNT_W'(TAG_DEPTH));
    bypass_s       = push_s && pop_s && empty_s;
    push_wr_s      = push_s && (!full_s || pop_s) && !bypass_s;
    pop_rd_s       = pop_s && !empty_s;
    tag_err_set_s  = (pop_s && empty_s && !push_s) || (push_s && full_s && !pop_s);
    tag_cnt_next_s = tag_cnt_r;
    if (push_wr_s && !pop_rd_s) begin
      tag_cnt_next_s = tag_cnt_r + CNT_W'(1);
    end else if (pop_rd_s && !push_wr_s) begin
      tag_cnt_next_s = tag_cnt_r - CNT_W'(1);
    end else begin
      tag_cnt_next_s = tag_cnt_r;
    end
    if (bypass_s) begin
      pop_tag_s = k_r;
    end else if (empty_s) begin
      pop_tag_s = '0;
    end else begin
      pop_tag_s = tag_mem_r[rd_ptr_r];
    end
    busy_next_s = (state_next_s != IDLE) || (tag_cnt_next_s != '0);
  end

  // A handshake in the same cycle makes the scheduler busy, so the write is refused.
  assign cfg_ok_s = cfg_we_i && !busy_r && !accept_s &&
                    ({1'b0, cfg_kidx_i} < (KIDX_W + 1)'(NUM_KERNELS)) &&
                    (cfg_row_i < 8'(WINDOW_HEIGHT)) && (cfg_col_i < 8'(WINDOW_WIDTH));

  // FSM state register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_r <= IDLE;
      k_r     <= '0;
    end else begin
      state_r <= state_next_s;
      k_r     <= k_next_s;
    end
  end

  // Engine issue registers plus handshake and busy status.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      win_r       <= '0;
      kernel_r    <= '0;
      col_lat_r   <= 16'h0000;
      row_lat_r   <= 16'h0000;
      eng_valid_r <= 1'b0;
      ready_r     <= 1'b1;
      busy_r      <= 1'b0;
    end else begin
      if (accept_s) begin
        win_r     <= window_i;
        col_lat_r <= col_i;
        row_lat_r <= row_i;
      end
      if (issue_next_s) begin
        kernel_r <= bank_r[k_next_s];
      end
      eng_valid_r <= issue_next_s;
      ready_r     <= ready_next_s;
      busy_r      <= busy_next_s;
    end
  end

  // Coefficient bank and config error pulse.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int kk = 0; kk < NUM_KERNELS; kk++) bank_r[kk] <= '0;
      cfg_err_r <= 1'b0;
    end else begin
      for (int kk = 0; kk < NUM_KERNELS; kk++) begin
        for (int r = 0; r < WINDOW_HEIGHT; r++) begin
          for (int c = 0; c < WINDOW_WIDTH; c++) begin
            if (cfg_ok_s && (cfg_kidx_i == KIDX_W'(kk)) && (cfg_row_i == 8'(r)) && (cfg_col_i == 8'(c))) begin
              bank_r[kk][r][c] <= cfg_data_i;
            end
          end
        end
      end
      cfg_err_r <= cfg_we_i && !cfg_ok_s;
    end
  end

  // Tag FIFO storage, pointers and sticky error.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < TAG_DEPTH; i++) tag_mem_r[i] <= '0;
      wr_ptr_r  <= '0;
      rd_ptr_r  <= '0;
      tag_cnt_r <= '0;
      tag_err_r <= 1'b0;
    end else begin
      if (push_wr_s) begin
        tag_mem_r[wr_ptr_r] <= k_r;
        wr_ptr_r            <= ptr_inc(wr_ptr_r);
      end
      if (pop_rd_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
      tag_cnt_r <= tag_cnt_next_s;
      tag_err_r <= tag_err_r || tag_err_set_s;
    end
  end

  // Result stage: engine output plus its kernel tag, one cycle later.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      data_r    <= '0;
      kidx_r    <= '0;
      res_col_r <= 16'h0000;
      res_row_r <= 16'h0000;
      valid_r   <= 1'b0;
    end else begin
      valid_r <= eng_valid_i;
      if (eng_valid_i) begin
        data_r    <= eng_data_i;
        kidx_r    <= pop_tag_s;
        res_col_r <= eng_col_i;
        res_row_r <= eng_row_i;
      end
    end
  end

  assign cfg_err_o    = cfg_err_r;
  assign ready_o      = ready_r;
  assign eng_window_o = win_r;
  assign eng_kernel_o = kernel_r;
  assign eng_col_o    = col_lat_r;
  assign eng_row_o    = row_lat_r;
  assign eng_valid_o  = eng_valid_r;
  assign data_o       = data_r;
  assign kidx_o       = kidx_r;
  assign col_o        = res_col_r;
  assign row_o        = res_row_r;
  assign valid_o      = valid_r;
  assign busy_o       = busy_r;
  assign tag_err_o    = tag_err_r;

endmodule

// File: tb/tb_conv_kernel_scheduler.sv
// Scoreboard bench for conv_kernel_scheduler: engine model with 8-cycle latency, directed windows.
`timescale 1ns/1ps
module tb_conv_kernel_scheduler;
  localparam int H = 5, W = 5, NK = 2, FPW = 16;
  typedef logic [H-1:0][W-1:0][FPW-1:0] win_t;
  typedef logic [15:0] vec5_t [5];
  typedef struct {
    logic        kidx;
    logic [15:0] data;
    logic [15:0] col;
    logic [15:0] row;
    int          cyc;
  } exp_t;

  logic clk_i = 1'b0;
  logic rst_i;
  logic cfg_we_i, cfg_err_o;
  logic [0:0] cfg_kidx_i;
  logic [7:0] cfg_row_i, cfg_col_i;
  logic [15:0] cfg_data_i;
  win_t window_i, eng_window_o, eng_kernel_o;
  logic [15:0] col_i, row_i, eng_col_o, eng_row_o, eng_data_i, eng_col_i, eng_row_i;
  logic valid_i, ready_o, eng_valid_o, eng_valid_i;
  logic [15:0] data_o, col_o, row_o;
  logic [0:0] kidx_o;
  logic valid_o, busy_o, tag_err_o;
`ifdef CONV_SCHED_MASK_EN
  logic [NK-1:0] kernel_mask_i;
`endif

  logic force_v;
  logic [15:0] force_d, force_c, force_r;
  logic [48:0] pipe_r [8];

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;
  exp_t sb_q[$];

  always #5 clk_i = ~clk_i;

  conv_kernel_scheduler dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cfg_we_i(cfg_we_i), .cfg_kidx_i(cfg_kidx_i), .cfg_row_i(cfg_row_i), .cfg_col_i(cfg_col_i),
    .cfg_data_i(cfg_data_i), .cfg_err_o(cfg_err_o),
    .window_i(window_i), .col_i(col_i), .row_i(row_i), .valid_i(valid_i),
`ifdef CONV_SCHED_MASK_EN
    .kernel_mask_i(kernel_mask_i),
`endif
    .ready_o(ready_o),
    .eng_window_o(eng_window_o), .eng_kernel_o(eng_kernel_o), .eng_col_o(eng_col_o),
    .eng_row_o(eng_row_o), .eng_valid_o(eng_valid_o),
    .eng_data_i(eng_data_i), .eng_col_i(eng_col_i), .eng_row_i(eng_row_i), .eng_valid_i(eng_valid_i),
    .data_o(data_o), .kidx_o(kidx_o), .col_o(col_o), .row_o(row_o), .valid_o(valid_o),
    .busy_o(busy_o), .tag_err_o(tag_err_o)
  );

  function automatic real h2r(input logic [15:0] h);
    int  e;
    real m;
    e = int'(h[14:10]);
    if (e == 0) return 0.0;
    m = 1.0 + real'(int'(h[9:0])) / 1024.0;
    while (e > 15) begin m = m * 2.0; e--; end
    while (e < 15) begin m = m / 2.0; e++; end
    return h[15] ? -m : m;
  endfunction

  function automatic logic [15:0] r2h(input real x);
    logic       s;
    int         e;
    real        a;
    logic [9:0] f;
    if (x == 0.0) return 16'h0000;
    s = (x < 0.0);
    a = s ? -x : x;
    e = 15;
    while (a >= 2.0) begin a = a / 2.0; e++; end
    while (a < 1.0) begin a = a * 2.0; e--; end
    f = 10'($rtoi((a - 1.0) * 1024.0));
    return {s, e[4:0], f};
  endfunction

  function automatic logic [15:0] dot(input win_t w, input win_t k);
    real acc;
    acc = 0.0;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        acc = acc + h2r(w[r][c]) * h2r(k[r][c]);
    return r2h(acc);
  endfunction

  function automatic win_t mk_win(input vec5_t row2, input vec5_t col2);
    win_t w;
    w = '0;
    for (int i = 0; i < 5; i++) w[2][i] = row2[i];
    for (int i = 0; i < 5; i++) w[i][2] = col2[i];
    return w;
  endfunction

  // Engine model shares the reset and returns the dot product 8 cycles after issue.
  always @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < 8; i++) pipe_r[i] <= '0;
    end else begin
      pipe_r[0] <= {eng_valid_o, dot(eng_window_o, eng_kernel_o), eng_col_o, eng_row_o};
      for (int i = 1; i < 8; i++) pipe_r[i] <= pipe_r[i-1];
    end
  end

  assign eng_valid_i = pipe_r[7][48] | force_v;
  assign eng_data_i  = force_v ? force_d : pipe_r[7][47:32];
  assign eng_col_i   = force_v ? force_c : pipe_r[7][31:16];
  assign eng_row_i   = force_v ? force_r : pipe_r[7][15:0];

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Monitor: every valid_o must match the oldest scoreboard entry, including its arrival cycle.
  always @(negedge clk_i) begin
    if (rst_i && valid_o) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected result: kidx %0d data %h col %h row %h at cycle %0d, required none",
                 kidx_o, data_o, col_o, row_o, cyc);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("result fields", 64'({kidx_o, data_o, col_o, row_o}), 64'({e.kidx, e.data, e.col, e.row}));
        check("result cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic expect_res(input logic k, input logic [15:0] d, input logic [15:0] c,
                            input logic [15:0] r, input int at);
    exp_t e;
    e.kidx = k; e.data = d; e.col = c; e.row = r; e.cyc = at;
    sb_q.push_back(e);
  endtask

  task automatic cfg_write(input int k, input int r, input int c, input logic [15:0] d,
                           input logic err, input string name);
    cfg_we_i = 1'b1; cfg_kidx_i = 1'(k); cfg_row_i = 8'(r); cfg_col_i = 8'(c); cfg_data_i = d;
    tick();
    cfg_we_i = 1'b0;
    check(name, 64'(cfg_err_o), 64'(err));
  endtask

  task automatic send(input win_t w, input logic [15:0] c, input logic [15:0] r,
                      input logic [NK-1:0] mask, output int t, input string name);
    int n;
    n = 0;
    while (!ready_o && n < 50) begin tick(); n++; end
    check({name, " ready"}, 64'(ready_o), 64'(1));
    window_i = w; col_i = c; row_i = r; valid_i = 1'b1;
`ifdef CONV_SCHED_MASK_EN
    kernel_mask_i = mask;
`else
    if (mask != 2'b11) $display("note: mask ignored in this build");
`endif
    t = cyc;
    tick();
    valid_i = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy_o && n < 200) begin tick(); n++; end
    check({name, " drained"}, 64'(busy_o), 64'(0));
    tick();
  endtask

  win_t  w0, w1, w2;
  vec5_t ra, ca;
  int    t;

  initial begin
    rst_i = 1'b0; cfg_we_i = 1'b0; cfg_kidx_i = 1'b0; cfg_row_i = 8'd0; cfg_col_i = 8'd0;
    cfg_data_i = 16'h0000; window_i = '0; col_i = 16'h0000; row_i = 16'h0000; valid_i = 1'b0;
    force_v = 1'b0; force_d = 16'h0000; force_c = 16'h0000; force_r = 16'h0000;
`ifdef CONV_SCHED_MASK_EN
    kernel_mask_i = 2'b11;
`endif
    ra = '{16'h3C00, 16'h4000, 16'h4200, 16'h4400, 16'h4500};
    ca = '{16'h3C00, 16'h4000, 16'h4200, 16'h4400, 16'h4500};
    w0 = mk_win(ra, ca);
    ra = '{16'h3C00, 16'h4000, 16'h4200, 16'h4400, 16'h4880};
    ca = '{16'h4000, 16'h0000, 16'h4200, 16'h0000, 16'h3C00};
    w1 = mk_win(ra, ca);
    ra = '{16'h4000, 16'h0000, 16'h4200, 16'h0000, 16'h4000};
    ca = '{16'h3800, 16'h0000, 16'h4200, 16'h0000, 16'h4300};
    w2 = mk_win(ra, ca);

    repeat (3) tick();
    rst_i = 1'b1;
    tick();
    check("reset ready", 64'(ready_o), 64'(1));
    check("reset busy", 64'(busy_o), 64'(0));
    check("reset valid", 64'(valid_o), 64'(0));
    check("reset tag_err", 64'(tag_err_o), 64'(0));
    check("reset eng_valid", 64'(eng_valid_o), 64'(0));

    // Cleared bank read back through one issue.
    send(w0, 16'd7, 16'd3, 2'b11, t, "zero bank");
    expect_res(1'b0, 16'h0000, 16'd7, 16'd3, t + 10);
    expect_res(1'b1, 16'h0000, 16'd7, 16'd3, t + 11);
    check("issue0 valid", 64'(eng_valid_o), 64'(1));
    check("issue0 kernel zero", 64'(eng_kernel_o == '0), 64'(1));
    check("issue0 window", 64'(eng_window_o == w0), 64'(1));
    check("issue0 col/row", 64'({eng_col_o, eng_row_o}), 64'({16'd7, 16'd3}));
    tick();
    check("issue1 valid", 64'(eng_valid_o), 64'(1));
    check("issue1 kernel zero", 64'(eng_kernel_o == '0), 64'(1));
    wait_idle("zero bank");

    // dx_1 into bank 0, dy_1 into bank 1.
    cfg_write(0, 2, 0, 16'hBC00, 1'b0, "cfg k0 r2 c0");
    cfg_write(0, 2, 4, 16'h3C00, 1'b0, "cfg k0 r2 c4");
    cfg_write(1, 0, 2, 16'hBC00, 1'b0, "cfg k1 r0 c2");
    cfg_write(1, 4, 2, 16'h3C00, 1'b0, "cfg k1 r4 c2");
    send(w0, 16'd7, 16'd3, 2'b11, t, "dx dy");
    expect_res(1'b0, 16'h4400, 16'd7, 16'd3, t + 10);
    expect_res(1'b1, 16'h4400, 16'd7, 16'd3, t + 11);
    wait_idle("dx dy");

    // Back-to-back windows with valid_i held high.
    t = cyc;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("b2b ready c%0d", i), 64'(ready_o), 64'((i >= 6) || (i % 2 == 0)));
      check($sformatf("b2b eng_valid c%0d", i), 64'(eng_valid_o), 64'((i >= 1) && (i <= 6)));
      valid_i = (i < 6);
      if (i == 0) begin
        window_i = w0; col_i = 16'd10; row_i = 16'd20;
        expect_res(1'b0, 16'h4400, 16'd10, 16'd20, t + 10);
        expect_res(1'b1, 16'h4400, 16'd10, 16'd20, t + 11);
      end else if (i == 2) begin
        window_i = w1; col_i = 16'd11; row_i = 16'd21;
        expect_res(1'b0, 16'h4800, 16'd11, 16'd21, t + 12);
        expect_res(1'b1, 16'hBC00, 16'd11, 16'd21, t + 13);
      end else if (i == 4) begin
        window_i = w2; col_i = 16'd12; row_i = 16'd22;
        expect_res(1'b0, 16'h0000, 16'd12, 16'd22, t + 14);
        expect_res(1'b1, 16'h4200, 16'd12, 16'd22, t + 15);
      end
      tick();
    end
    valid_i = 1'b0;
    wait_idle("b2b");

    // Config writes refused: with a handshake, while busy, out-of-range row and column.
    cfg_we_i = 1'b1; cfg_kidx_i = 1'b0; cfg_row_i = 8'd2; cfg_col_i = 8'd4; cfg_data_i = 16'h0000;
    window_i = w0; col_i = 16'd7; row_i = 16'd3; valid_i = 1'b1;
    t = cyc;
    tick();
    valid_i = 1'b0; cfg_we_i = 1'b0;
    check("cfg with handshake err", 64'(cfg_err_o), 64'(1));
    expect_res(1'b0, 16'h4400, 16'd7, 16'd3, t + 10);
    expect_res(1'b1, 16'h4400, 16'd7, 16'd3, t + 11);
    cfg_write(1, 4, 2, 16'h0000, 1'b1, "cfg during issue err");
    wait_idle("cfg busy");
    cfg_write(0, 5, 2, 16'h0000, 1'b1, "cfg row5 err");
    cfg_write(0, 2, 5, 16'h0000, 1'b1, "cfg col5 err");
    send(w0, 16'd7, 16'd3, 2'b11, t, "bank unchanged");
    expect_res(1'b0, 16'h4400, 16'd7, 16'd3, t + 10);
    expect_res(1'b1, 16'h4400, 16'd7, 16'd3, t + 11);
    wait_idle("bank unchanged");

    // Result with no tag outstanding.
    force_v = 1'b1; force_d = 16'h1234; force_c = 16'h0055; force_r = 16'h00AA;
    t = cyc;
    expect_res(1'b0, 16'h1234, 16'h0055, 16'h00AA, t + 1);
    tick();
    force_v = 1'b0;
    check("underflow tag_err", 64'(tag_err_o), 64'(1));
    repeat (3) tick();
    check("underflow tag_err sticky", 64'(tag_err_o), 64'(1));
    check("underflow busy", 64'(busy_o), 64'(0));

    // Reset on the cycle after the first issue.
    send(w0, 16'd1, 16'd2, 2'b11, t, "reset mid issue");
    check("pre-reset eng_valid", 64'(eng_valid_o), 64'(1));
    tick();
    rst_i = 1'b0;
    #1;
    check("reset eng_valid now", 64'(eng_valid_o), 64'(0));
    check("reset busy now", 64'(busy_o), 64'(0));
    check("reset tag_err cleared", 64'(tag_err_o), 64'(0));
    tick();
    rst_i = 1'b1;
    tick();
    check("post-reset ready", 64'(ready_o), 64'(1));
    check("post-reset busy", 64'(busy_o), 64'(0));
    repeat (15) tick();
    check("post-reset busy idle", 64'(busy_o), 64'(0));

`ifdef CONV_SCHED_MASK_EN
    cfg_write(0, 2, 0, 16'hBC00, 1'b0, "recfg k0 r2 c0");
    cfg_write(0, 2, 4, 16'h3C00, 1'b0, "recfg k0 r2 c4");
    cfg_write(1, 0, 2, 16'hBC00, 1'b0, "recfg k1 r0 c2");
    cfg_write(1, 4, 2, 16'h3C00, 1'b0, "recfg k1 r4 c2");
    send(w1, 16'd9, 16'd8, 2'b10, t, "mask 10");
    expect_res(1'b1, 16'hBC00, 16'd9, 16'd8, t + 10);
    check("mask10 ready on last", 64'(ready_o), 64'(1));
    tick();
    check("mask10 single issue", 64'(eng_valid_o), 64'(0));
    wait_idle("mask 10");
    send(w1, 16'd9, 16'd8, 2'b00, t, "mask 00");
    check("mask00 no issue", 64'(eng_valid_o), 64'(0));
    check("mask00 idle", 64'(busy_o), 64'(0));
`endif

    repeat (20) tick();
    check("scoreboard empty", 64'(sb_q.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
